// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register with operand forwarding from EX and MEM, plus load-use
// hazard detection. Bubbles are all-zero so an invalid slot can never write back.
module pipe_id_ex (
  input  logic        clock,
  input  logic        reset,
  // ID stage
  input  logic        d_valid,
  input  logic [31:0] d_ra,
  input  logic [31:0] d_rb,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [4:0]  d_rn,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic [31:0] d_imm,
  input  logic [4:0]  d_sa,
  input  logic [4:0]  d_aluc,
  input  logic        d_aluimm,
  input  logic        d_shift,
  input  logic        d_wreg,
  input  logic        d_m2reg,
  input  logic        d_wmem,
  // EX result and MEM writeback info
  input  logic [31:0] ex_r,
  input  logic        m_wreg,
  input  logic        m_m2reg,
  input  logic [4:0]  m_rn,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_mem,
  // Pipeline control
  input  logic        flush,
  input  logic        hold,
  output logic        stall_id,
  // EX stage
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [31:0] e_store,
  output logic [4:0]  e_aluc,
  output logic        e_wreg,
  output logic        e_m2reg,
  output logic        e_wmem,
  output logic        e_valid,
  output logic [4:0]  e_rn
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store;
    logic [4:0]  aluc;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        valid;
    logic [4:0]  rn;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;

  logic        ex_writes_alu;
  logic        ex_writes_load;
  logic        mem_writes;
  logic [31:0] mem_data;
  logic        ex_hit_rs, ex_hit_rt;
  logic        mem_hit_rs, mem_hit_rt;
  logic        load_use;
  logic [31:0] fwd_rs, fwd_rt;

  // r0 is excluded from every match so it is never forwarded or stalled on.
  assign ex_writes_alu  = ex_q.valid & ex_q.wreg & ~ex_q.m2reg & (ex_q.rn != 5'd0);
  assign ex_writes_load = ex_q.valid & ex_q.wreg & ex_q.m2reg & (ex_q.rn != 5'd0);
  assign mem_writes     = m_wreg & (m_rn != 5'd0);
  assign mem_data       = m_m2reg ? m_mem : m_alu;

  assign ex_hit_rs  = ex_writes_alu & (ex_q.rn == d_rs);
  assign ex_hit_rt  = ex_writes_alu & (ex_q.rn == d_rt);
  assign mem_hit_rs = mem_writes & (m_rn == d_rs);
  assign mem_hit_rt = mem_writes & (m_rn == d_rt);

  assign load_use = ex_writes_load & d_valid &
                    ((d_use_rs & (ex_q.rn == d_rs)) | (d_use_rt & (ex_q.rn == d_rt)));

  always_comb begin
    if (ex_hit_rs)       fwd_rs = ex_r;
    else if (mem_hit_rs) fwd_rs = mem_data;
    else                 fwd_rs = d_ra;
  end

  always_comb begin
    if (ex_hit_rt)       fwd_rt = ex_r;
    else if (mem_hit_rt) fwd_rt = mem_data;
    else                 fwd_rt = d_rb;
  end

  // A flush replaces the ID instruction, so a pending load-use is irrelevant then.
  assign stall_id = ~reset & (hold | (load_use & ~flush));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d.a     = d_shift ? {27'b0, d_sa} : fwd_rs;
      ex_d.b     = d_aluimm ? d_imm : fwd_rt;
      ex_d.store = fwd_rt;
      ex_d.aluc  = d_aluc;
      ex_d.wreg  = d_valid & d_wreg;
      ex_d.m2reg = d_m2reg;
      ex_d.wmem  = d_valid & d_wmem;
      ex_d.valid = d_valid;
      ex_d.rn    = d_rn;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign e_a     = ex_q.a;
  assign e_b     = ex_q.b;
  assign e_store = ex_q.store;
  assign e_aluc  = ex_q.aluc;
  assign e_wreg  = ex_q.wreg;
  assign e_m2reg = ex_q.m2reg;
  assign e_wmem  = ex_q.wmem;
  assign e_valid = ex_q.valid;
  assign e_rn    = ex_q.rn;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Randomized plus directed bench for pipe_id_ex against a behavioural reference
// model of the ID/EX register, forwarding priorities and load-use stalls.
module tb_pipe_id_ex;

  logic        clock = 1'b0;
  logic        reset;
  logic        d_valid, d_use_rs, d_use_rt, d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem;
  logic [31:0] d_ra, d_rb, d_imm, ex_r, m_alu, m_mem;
  logic [4:0]  d_rs, d_rt, d_rn, d_sa, d_aluc, m_rn;
  logic        m_wreg, m_m2reg, flush, hold;
  logic        stall_id;
  logic [31:0] e_a, e_b, e_store;
  logic [4:0]  e_aluc, e_rn;
  logic        e_wreg, e_m2reg, e_wmem, e_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference EX-stage contents
  logic [31:0] r_a, r_b, r_store;
  logic [4:0]  r_aluc, r_rn;
  logic        r_wreg, r_m2reg, r_wmem, r_valid;

  pipe_id_ex dut (
    .clock(clock), .reset(reset),
    .d_valid(d_valid), .d_ra(d_ra), .d_rb(d_rb), .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_imm(d_imm), .d_sa(d_sa), .d_aluc(d_aluc),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
    .d_wmem(d_wmem), .ex_r(ex_r), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
    .m_alu(m_alu), .m_mem(m_mem), .flush(flush), .hold(hold), .stall_id(stall_id),
    .e_a(e_a), .e_b(e_b), .e_store(e_store), .e_aluc(e_aluc), .e_wreg(e_wreg),
    .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_valid(e_valid), .e_rn(e_rn)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    r_a = '0; r_b = '0; r_store = '0; r_aluc = '0; r_rn = '0;
    r_wreg = 0; r_m2reg = 0; r_wmem = 0; r_valid = 0;
  endfunction

  // Newest producer wins: the EX instruction is younger than the MEM one.
  function automatic logic [31:0] source_value(input logic [4:0] x, input logic [31:0] rf);
    if (x == 0) return rf;
    if (r_valid && r_wreg && !r_m2reg && r_rn == x) return ex_r;
    if (m_wreg && m_rn == x) return m_m2reg ? m_mem : m_alu;
    return rf;
  endfunction

  function automatic logic model_load_use();
    if (!(r_valid && r_wreg && r_m2reg) || r_rn == 0 || !d_valid) return 1'b0;
    return (d_use_rs && r_rn == d_rs) || (d_use_rt && r_rn == d_rt);
  endfunction

  function automatic logic model_stall();
    if (reset) return 1'b0;
    if (hold) return 1'b1;
    return model_load_use() && !flush;
  endfunction

  function automatic void model_edge();
    if (reset || flush) begin
      model_clear();
    end else if (hold) begin
      // unchanged
    end else if (model_load_use()) begin
      model_clear();
    end else begin
      logic [31:0] vs, vt;
      vs = source_value(d_rs, d_ra);
      vt = source_value(d_rt, d_rb);
      r_a     = d_shift ? {27'b0, d_sa} : vs;
      r_b     = d_aluimm ? d_imm : vt;
      r_store = vt;
      r_aluc  = d_aluc;
      r_wreg  = d_valid && d_wreg;
      r_m2reg = d_m2reg;
      r_wmem  = d_valid && d_wmem;
      r_valid = d_valid;
      r_rn    = d_rn;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".e_a"}, e_a, r_a);
    check({tag, ".e_b"}, e_b, r_b);
    check({tag, ".e_store"}, e_store, r_store);
    check({tag, ".e_aluc"}, 32'(e_aluc), 32'(r_aluc));
    check({tag, ".e_rn"}, 32'(e_rn), 32'(r_rn));
    check({tag, ".ctl"}, {28'b0, e_valid, e_wreg, e_m2reg, e_wmem},
          {28'b0, r_valid, r_wreg, r_m2reg, r_wmem});
  endtask

  task automatic clear_inputs();
    d_valid = 0; d_ra = '0; d_rb = '0; d_rs = '0; d_rt = '0; d_rn = '0;
    d_use_rs = 0; d_use_rt = 0; d_imm = '0; d_sa = '0; d_aluc = '0;
    d_aluimm = 0; d_shift = 0; d_wreg = 0; d_m2reg = 0; d_wmem = 0;
    ex_r = '0; m_wreg = 0; m_m2reg = 0; m_rn = '0; m_alu = '0; m_mem = '0;
    flush = 0; hold = 0;
  endtask

  task automatic randomize_inputs();
    d_valid  = ($urandom_range(0, 7) != 0);
    d_ra     = $urandom; d_rb = $urandom; d_imm = $urandom;
    d_rs     = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
    d_rn     = 5'($urandom_range(0, 3));
    d_use_rs = $urandom_range(0, 1); d_use_rt = $urandom_range(0, 1);
    d_sa     = 5'($urandom); d_aluc = 5'($urandom);
    d_aluimm = $urandom_range(0, 1); d_shift = ($urandom_range(0, 3) == 0);
    d_wreg   = $urandom_range(0, 1); d_m2reg = $urandom_range(0, 1);
    d_wmem   = $urandom_range(0, 1);
    ex_r     = $urandom; m_alu = $urandom; m_mem = $urandom;
    m_wreg   = $urandom_range(0, 1); m_m2reg = $urandom_range(0, 1);
    m_rn     = 5'($urandom_range(0, 3));
    flush    = ($urandom_range(0, 9) == 0);
    hold     = ($urandom_range(0, 7) == 0);
  endtask

  // Inputs must be stable when called (driven after the falling edge).
  task automatic cycle(input string tag);
    #1;
    check({tag, ".stall_id"}, 32'(stall_id), 32'(model_stall()));
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] held_a;
    clear_inputs();
    reset = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
    check_outputs("reset");
    check("reset.stall_id", 32'(stall_id), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back add: EX writes r3
    d_valid = 1; d_wreg = 1; d_rn = 5'd3; d_aluc = 5'd2;
    cycle("add_setup");
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_rs = 5'd3; d_use_rs = 1; d_ra = 32'h99; ex_r = 32'h10;
    cycle("b2b");
    check("b2b.e_a_const", e_a, 32'h10);

    // Dual hit on r5: EX (ex_r=1) beats MEM (m_alu=2)
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_rn = 5'd5;
    cycle("dual_setup");
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_rt = 5'd5; d_use_rt = 1; d_rb = 32'h77;
    ex_r = 32'd1; m_wreg = 1; m_rn = 5'd5; m_alu = 32'd2;
    cycle("dual");
    check("dual.e_b_const", e_b, 32'd1);
    check("dual.e_store_const", e_store, 32'd1);

    // Load-use on r7: one bubble, then forward from MEM load data
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_m2reg = 1; d_rn = 5'd7;
    cycle("lw_setup");
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_rs = 5'd7; d_use_rs = 1; d_ra = 32'h1234; d_wreg = 1; d_rn = 5'd8;
    #1;
    check("lu.stall_const", 32'(stall_id), 32'd1);
    cycle("lu");
    check("lu.e_valid_const", 32'(e_valid), 32'd0);
    @(negedge clock);
    m_wreg = 1; m_m2reg = 1; m_rn = 5'd7; m_mem = 32'hABCD; m_alu = 32'h5555;
    cycle("lu_fwd");
    check("lu_fwd.e_a_const", e_a, 32'hABCD);

    // r0 target: EX lw r0 must neither stall nor forward
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_m2reg = 1; d_rn = 5'd0;
    cycle("r0_setup");
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_rs = 5'd0; d_use_rs = 1; d_ra = 32'd0; ex_r = 32'h55;
    m_wreg = 1; m_rn = 5'd0; m_alu = 32'h66;
    #1;
    check("r0.stall_const", 32'(stall_id), 32'd0);
    cycle("r0");
    check("r0.e_a_const", e_a, 32'd0);

    // flush + hold on the same edge bubbles a valid instruction
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_wmem = 1; d_rn = 5'd4; d_ra = 32'hCAFE;
    cycle("fh_setup");
    @(negedge clock);
    flush = 1; hold = 1;
    cycle("flush_hold");
    check("flush_hold.valid_wreg", {30'b0, e_valid, e_wreg}, 32'd0);

    // hold alone freezes the stage for three cycles
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_rn = 5'd9; d_ra = 32'hBEEF; d_aluc = 5'd7;
    cycle("hold_setup");
    held_a = r_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      randomize_inputs();
      flush = 0; hold = 1;
      cycle($sformatf("hold%0d", i));
    end
    check("hold.e_a_const", e_a, held_a);

    // Asynchronous reset between edges with a valid writing instruction in EX
    @(negedge clock);
    clear_inputs();
    d_valid = 1; d_wreg = 1; d_rn = 5'd6; d_ra = 32'h1;
    cycle("ar_setup");
    check("ar_setup.valid_wreg", {30'b0, e_valid, e_wreg}, 32'd3);
    #1 reset = 1'b1;
    model_clear();
    #1;
    check_outputs("async_reset");
    check("async_reset.stall_id", 32'(stall_id), 32'd0);
    @(negedge clock);
    randomize_inputs();
    cycle("in_reset");
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      randomize_inputs();
      cycle($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_id_ex.md
PIPE_ID_EX -- requirements
Module: pipe_id_ex

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all registered outputs immediately.
REQ-004 d_valid  in  1  ID slot holds a real instruction.
REQ-005 d_ra, d_rb  in  32 each  register-file read data for rs, rt.
REQ-006 d_rs, d_rt, d_rn  in  5 each  source and destination register numbers.
REQ-007 d_use_rs, d_use_rt  in  1 each  instruction actually reads rs / rt.
REQ-008 d_imm  in  32  pre-extended immediate; d_sa  in  5  shift amount.
REQ-009 d_aluc  in  5  ALU op code; d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem  in  1 each  decoded controls.
REQ-010 ex_r  in  32  current ALU result of the instruction in EX.
REQ-011 m_wreg, m_m2reg  in  1; m_rn  in  5; m_alu, m_mem  in  32  MEM-stage writeback info and data.
REQ-012 flush  in  1  kill ID instruction (branch taken); hold  in  1  freeze whole stage (downstream busy).
REQ-013 stall_id  out  1  combinational; ID/IF must not advance this cycle.
REQ-014 e_a, e_b, e_store  out  32 each  registered ALU operand a, operand b, store data.
REQ-015 e_aluc  out  5; e_wreg, e_m2reg, e_wmem, e_valid  out  1; e_rn  out  5  registered EX controls.

Function
REQ-016 Forward source X (rs or rt) SHALL select, in priority: EX hit -> ex_r; MEM hit -> (m_m2reg ? m_mem : m_alu); else d_ra/d_rb.
REQ-017 EX hit = e_valid & e_wreg & ~e_m2reg & e_rn!=0 & e_rn==X; MEM hit = m_wreg & m_rn!=0 & m_rn==X.
REQ-018 Register 0 SHALL never be forwarded; reads of r0 always take register-file data.
REQ-019 Load-use = e_valid & e_wreg & e_m2reg & e_rn!=0 & ((d_use_rs & e_rn==d_rs) | (d_use_rt & e_rn==d_rt)) & d_valid.
REQ-020 stall_id SHALL equal hold | load-use, and SHALL be 0 when flush=1 and hold=0.
REQ-021 Captured e_a SHALL be d_shift ? {27'b0,d_sa} : fwd_rs; e_b SHALL be d_aluimm ? d_imm : fwd_rt; e_store SHALL be fwd_rt.
REQ-022 Per-edge priority: reset > flush > hold > load-use > capture.
REQ-023 flush: register loads a bubble (e_valid=0, e_wreg=0, e_wmem=0, e_m2reg=0, data/aluc=0), even if hold=1.
REQ-024 hold (no flush): every registered output keeps its value.
REQ-025 load-use (no flush/hold): bubble inserted exactly as REQ-023; ID instruction re-presented next cycle.
REQ-026 capture: all outputs load from ID; e_valid=d_valid; e_wreg/e_wmem forced 0 when d_valid=0.
REQ-027 Load-use SHALL last exactly one cycle per load: after the bubble the load is in MEM and REQ-016 forwards m_mem.
REQ-028 Latency: one clock from ID inputs to e_* outputs; no combinational path from d_* to e_*.

Reset
REQ-029 While reset=1, all e_* outputs SHALL be 0 (e_aluc=5'b0, e_valid=0), independent of clock.
REQ-030 Reset deassertion mid-stream: first edge after release performs normal REQ-022 evaluation; no spurious writeback enabled.
REQ-031 stall_id SHALL be 0 during reset (e_valid=0 suppresses load-use).

Verification
REQ-032 Back-to-back add: EX holds r3 write, ex_r=0x10; ID reads rs=3, d_ra=0x99 -> next cycle e_a=0x10.
REQ-033 Dual hit: EX and MEM both write r5 (ex_r=1, m_alu=2); ID rt=5, aluimm=0 -> e_b=1, e_store=1.
REQ-034 Load-use: EX lw r7, ID uses rs=7 -> stall_id=1, next e_valid=0; following cycle MEM m_m2reg=1, m_mem=0xABCD -> e_a=0xABCD.
REQ-035 r0 target: EX writes r0, ex_r=0x55; ID reads rs=0, d_ra=0 -> e_a=0, stall_id=0 even if EX is lw r0.
REQ-036 flush+hold same edge with valid ID -> e_valid=0, e_wreg=0; hold alone -> all e_* unchanged for 3 cycles.
REQ-037 Assert reset between clock edges with e_valid=1, e_wreg=1 -> outputs 0 immediately, before next edge.
